// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of uart_tx_fifo: push handshake plus the FIFO status flags.
// The producer (register block) owns the master modport, the transmitter the slave.
interface uart_tx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;

    modport master (
        output wr_en, wr_data,
        input  fifo_empty, fifo_full, fifo_level, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output fifo_empty, fifo_full, fifo_level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated FIFO; frames of 5..DATA_W bits, optional parity, 1/2 stops.
// Define UART_TX_BREAK_EN to add the tx_break input and the BREAK line state.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                tx_baud_pulse,
    uart_tx_fifo_if.slave       wr_if,
    input  logic [3:0]          char_len,
    input  logic                parity_en,
    input  logic                parity_odd0_even1,
    input  logic                stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                tx_break,
`endif
    output logic                UART_TX,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0] MAX_LEN = 4'(DATA_W);
    localparam logic [3:0] MIN_LEN = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        len_q, len_d;
    logic              par_en_q, par_en_d;
    logic              par_even_q, par_even_d;
    logic              stop2_q, stop2_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              tx_done_q, tx_done_d;

    logic              push;
    logic              pop;
    logic              start_frame;
    logic              break_req;
    logic [3:0]        len_clamped;

`ifdef UART_TX_BREAK_EN
    assign break_req = tx_break;
`else
    assign break_req = 1'b0;
`endif

    // Character length is clamped once here and latched per frame.
    always_comb begin
        if (char_len < MIN_LEN) begin
            len_clamped = MIN_LEN;
        end else if (char_len > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end else begin
            len_clamped = char_len;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        par_en_d    = par_en_q;
        par_even_d  = par_even_q;
        stop2_d     = stop2_q;
        stop_cnt_d  = stop_cnt_q;
        par_d       = par_q;
        tx_d        = tx_q;
        tx_done_d   = 1'b0;
        start_frame = 1'b0;

        if (tx_baud_pulse) begin
            unique case (state_q)
                S_IDLE: begin
                    if (break_req) begin
`ifdef UART_TX_BREAK_EN
                        state_d = S_BREAK;
                        tx_d    = 1'b0;
`endif
                    end else if (!empty_q) begin
                        start_frame = 1'b1;
                    end
                end

                S_START: begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    par_d     = par_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                end

                S_DATA: begin
                    if (bit_cnt_q == len_q - 4'd1) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_q ^ ~par_even_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shift_q[0];
                        par_d     = par_q ^ shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end

                S_PARITY: begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end

                S_STOP: begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        tx_done_d = 1'b1;
                        if (break_req) begin
`ifdef UART_TX_BREAK_EN
                            state_d = S_BREAK;
                            tx_d    = 1'b0;
`endif
                        end else if (!empty_q) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end

`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (!break_req) begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
`endif

                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Back-to-back frames reuse this path from STOP, so the start-of-frame load lives here once.
        if (start_frame) begin
            state_d    = S_START;
            tx_d       = 1'b0;
            shift_d    = mem_q[rd_ptr_q];
            len_d      = len_clamped;
            par_en_d   = parity_en;
            par_even_d = parity_odd0_even1;
            stop2_d    = stop2;
            par_d      = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign pop = start_frame;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        push       = wr_if.wr_en && (!full_q || pop);
        overflow_d = wr_if.wr_en && full_q && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        empty_d    = (level_d == '0);
        full_d     = (level_d == LVL_W'(FIFO_DEPTH));
    end

    // NOTE: the storage array has no reset; the pointers and level define what is valid.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_if.wr_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            len_q      <= MIN_LEN;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_even_q <= par_even_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign UART_TX          = tx_q;
    assign tx_busy          = busy_q;
    assign tx_done          = tx_done_q;
    assign wr_if.fifo_empty = empty_q;
    assign wr_if.fifo_full  = full_q;
    assign wr_if.fifo_level = level_q;
    assign wr_if.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frames plus random traffic against a
// queue-based line model. Covers the tx_break path when UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       tx_baud_pulse = 1'b0;
    logic [3:0] char_len = 4'd8;
    logic       parity_en = 1'b0;
    logic       parity_odd0_even1 = 1'b0;
    logic       stop2 = 1'b0;
    logic       tx_break = 1'b0;
    logic       UART_TX;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) wr_if ();

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) dut (
        .ACLK              (ACLK),
        .ARESETn           (ARESETn),
        .tx_baud_pulse     (tx_baud_pulse),
        .wr_if             (wr_if),
        .char_len          (char_len),
        .parity_en         (parity_en),
        .parity_odd0_even1 (parity_odd0_even1),
        .stop2             (stop2),
`ifdef UART_TX_BREAK_EN
        .tx_break          (tx_break),
`endif
        .UART_TX           (UART_TX),
        .tx_busy           (tx_busy),
        .tx_done           (tx_done)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Reference model: pending characters, bits left of the current frame, line level.
    logic [7:0] m_fifo[$];
    bit         m_cur[$];
    bit         m_line_log[$];
    bit         m_in_frame = 1'b0;
    bit         m_in_break = 1'b0;
    bit         m_line = 1'b1;
    int         done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A frame is start bit, len data bits LSB first, optional parity, then the stop bits.
    task automatic build_frame(input logic [7:0] b);
        int len;
        int ones;
        len = (char_len < 5) ? 5 : ((char_len > DATA_W) ? DATA_W : int'(char_len));
        ones = 0;
        m_cur.delete();
        m_cur.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            m_cur.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (parity_en) begin
            if (parity_odd0_even1) m_cur.push_back(bit'(ones % 2));
            else                   m_cur.push_back(bit'((ones + 1) % 2));
        end
        m_cur.push_back(1'b1);
        if (stop2) m_cur.push_back(1'b1);
    endtask

    task automatic step(input bit push, input logic [7:0] d, input bit baud);
        bit exp_done;
        bit exp_ovf;
        bit popped;
        int lvl_before;
        exp_done = 1'b0;
        exp_ovf  = 1'b0;
        popped   = 1'b0;
        @(negedge ACLK);
        wr_if.wr_en   = push;
        wr_if.wr_data = d;
        tx_baud_pulse = baud;
        lvl_before = m_fifo.size();
        if (baud) begin
            if (m_in_break) begin
                if (!tx_break) begin
                    m_in_break = 1'b0;
                    m_line     = 1'b1;
                end
            end else begin
                if (m_in_frame && m_cur.size() == 0) begin
                    exp_done   = 1'b1;
                    m_in_frame = 1'b0;
                end
                if (!m_in_frame) begin
                    if (tx_break) begin
                        m_in_break = 1'b1;
                        m_line     = 1'b0;
                    end else if (m_fifo.size() != 0) begin
                        build_frame(m_fifo.pop_front());
                        m_in_frame = 1'b1;
                        popped     = 1'b1;
                    end else begin
                        m_line = 1'b1;
                    end
                end
                if (m_in_frame) m_line = m_cur.pop_front();
            end
        end
        if (push) begin
            if (lvl_before < FIFO_DEPTH || popped) m_fifo.push_back(d);
            else exp_ovf = 1'b1;
        end
        @(posedge ACLK);
        #1;
        check("line", UART_TX, m_line);
        check("tx_done", tx_done, exp_done);
        check("tx_busy", tx_busy, m_in_frame || m_in_break);
        check("fifo_level", wr_if.fifo_level, m_fifo.size());
        check("fifo_empty", wr_if.fifo_empty, m_fifo.size() == 0);
        check("fifo_full", wr_if.fifo_full, m_fifo.size() == FIFO_DEPTH);
        check("overflow", wr_if.overflow, exp_ovf);
        if (baud) m_line_log.push_back(UART_TX);
        if (tx_done) done_seen++;
    endtask

    task automatic drain();
        tx_break = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!m_in_frame && !m_in_break && m_fifo.size() == 0) break;
            step(1'b0, 8'h00, 1'b1);
        end
        step(1'b0, 8'h00, 1'b1);
        check("drain_busy", tx_busy, 1'b0);
    endtask

    logic [10:0] frame_bits;
    int          done_base;

    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_data = '0;

        // Reset state
        #22;
        check("rst_line", UART_TX, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_empty", wr_if.fifo_empty, 1'b1);
        check("rst_full", wr_if.fifo_full, 1'b0);
        check("rst_level", wr_if.fifo_level, 0);
        check("rst_ovf", wr_if.overflow, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Idle line under baud pulses
        repeat (20) step(1'b0, 8'h00, 1'b1);

        // 8N1, 0xA5
        step(1'b1, 8'hA5, 1'b0);
        m_line_log.delete();
        done_base = done_seen;
        repeat (11) step(1'b0, 8'h00, 1'b1);
        frame_bits = '0;
        for (int i = 0; i < 10; i++) frame_bits[i] = m_line_log[i];
        check("frame_a5", frame_bits[9:0], 10'b1101001010);
        check("done_a5", done_seen - done_base, 1);

        // 7E2, 0x41
        char_len = 4'd7; parity_en = 1'b1; parity_odd0_even1 = 1'b1; stop2 = 1'b1;
        step(1'b1, 8'h41, 1'b0);
        m_line_log.delete();
        done_base = done_seen;
        repeat (13) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 11; i++) frame_bits[i] = m_line_log[i];
        check("frame_41", frame_bits, 11'b11010000010);
        check("done_41", done_seen - done_base, 1);

        // Three back-to-back frames
        char_len = 4'd8; parity_en = 1'b0; parity_odd0_even1 = 1'b0; stop2 = 1'b0;
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        check("level_3", wr_if.fifo_level, 3);
        done_base = done_seen;
        m_line_log.delete();
        repeat (31) step(1'b0, 8'h00, 1'b1);
        check("done_3", done_seen - done_base, 3);
        check("gap_f2", m_line_log[10], 1'b0);
        check("gap_f3", m_line_log[20], 1'b0);

        // Fill past capacity with no baud pulses
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
            if (i == 15) begin
                check("full_16", wr_if.fifo_full, 1'b1);
                check("level_16", wr_if.fifo_level, 16);
            end
        end
        check("ovf_17", wr_if.overflow, 1'b1);
        // Push while full on the popping pulse is accepted
        step(1'b1, 8'hEE, 1'b1);
        drain();

`ifdef UART_TX_BREAK_EN
        // Break requested mid-frame waits for the frame to finish
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        tx_break = 1'b1;
        repeat (14) step(1'b0, 8'h00, 1'b1);
        check("break_low", UART_TX, 1'b0);
        check("break_busy", tx_busy, 1'b1);
        check("break_held", wr_if.fifo_level, 1);
        tx_break = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        check("break_exit", UART_TX, 1'b1);
        drain();
`endif

        // Random traffic with random configuration
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                char_len          = 4'($urandom_range(0, 15));
                parity_en         = 1'($urandom_range(0, 1));
                parity_odd0_even1 = 1'($urandom_range(0, 1));
                stop2             = 1'($urandom_range(0, 1));
            end
`ifdef UART_TX_BREAK_EN
            if ($urandom_range(0, 63) == 0) tx_break = ~tx_break;
`endif
            step(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        drain();

        // Reset in the middle of a frame
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("mid_rst_line", UART_TX, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_empty", wr_if.fifo_empty, 1'b1);
        check("mid_rst_level", wr_if.fifo_level, 0);
        m_fifo.delete();
        m_cur.delete();
        m_in_frame = 1'b0;
        m_in_break = 1'b0;
        m_line     = 1'b1;
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (12) step(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmit engine with an integrated transmit FIFO, the next-generation replacement for the single-buffer UART transmitter. Software writes characters from the register block into a FIFO of FIFO_DEPTH entries. A frame FSM serialises them back-to-back on UART_TX, paced by the existing baud generator's tx_baud_pulse. Character length (5..DATA_W), parity and 1 or 2 stop bits are selectable per frame.

Parameters:
DATA_W, 8, maximum character length in bits (legal 5..9)
FIFO_DEPTH, 16, FIFO entries (power of 2, >=2)
LVL_W, $clog2(FIFO_DEPTH)+1, width of the fifo_level output

Ports:
ACLK  input  1  system clock; all logic on rising edge
ARESETn  input  1  asynchronous active-low reset
tx_baud_pulse  input  1  one-ACLK pulse per bit period, from baud_clk_gen
wr_en  input  1  push request; one character per cycle
wr_data  input  DATA_W  character to push, LSB = first bit on the line
char_len  input  4  character length in bits; values <5 act as 5, values >DATA_W act as DATA_W
parity_en  input  1  1 = append a parity bit
parity_odd0_even1  input  1  0 = odd parity, 1 = even parity
stop2  input  1  0 = one stop bit, 1 = two stop bits
UART_TX  output  1  serial line, idle high
tx_busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse at end of each frame
fifo_empty  output  1  FIFO holds 0 entries
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_level  output  LVL_W  current FIFO occupancy
overflow  output  1  one-cycle pulse when a push is dropped

Behaviour:
- Reset (async assert, sync release): UART_TX=1, tx_busy=0, tx_done=0, fifo_empty=1, fifo_full=0, fifo_level=0, overflow=0, FSM=IDLE, pointers=0.
- FIFO: synchronous write/read pointers, wrapping modulo FIFO_DEPTH. fifo_level, fifo_empty and fifo_full are registered and update in the cycle after a push or pop.
- Push: wr_en & !fifo_full writes wr_data. wr_en & fifo_full with no same-cycle pop drops the data and pulses overflow for 1 cycle. wr_en & fifo_full with a same-cycle pop is accepted; level is unchanged.
- Pop occurs only when registered fifo_empty=0. There is no write-to-line bypass: a character pushed into an empty FIFO can start no earlier than the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions happen only on cycles with tx_baud_pulse=1.
- IDLE: when fifo_empty=0 and tx_baud_pulse, pop the head into the shift register. Latch char_len (clamped), parity_en, parity_odd0_even1 and stop2 into frame-config registers. Go to START and drive UART_TX=0.
- START: 1 bit period. Then go to DATA with bit count=0.
- DATA: drive shift[0], shift right each pulse. After latched char_len bits, go to PARITY if parity enabled, else STOP.
- PARITY: drive XOR of the char_len data bits; invert it when odd parity is latched. 1 bit period, then STOP.
- STOP: UART_TX=1 for 1 or 2 bit periods. On the pulse ending the last stop bit, assert tx_done for 1 cycle. If the FIFO is non-empty, pop and enter START on that same pulse (no idle gap). Otherwise go to IDLE.
- UART_TX is registered and changes only on the cycle after a tx_baud_pulse.
- Config inputs changing mid-frame have no effect until the next frame start.
- Data bits above the latched char_len are ignored.
- Reset mid-frame aborts the frame, UART_TX returns high immediately and FIFO contents are discarded.

Optional Feature:
Macro UART_TX_BREAK_EN. When defined, add input port tx_break (1 bit).
- tx_break=1 in IDLE, or at the end of the current frame, moves the FSM to state BREAK. BREAK holds UART_TX=0 and tx_busy=1 without popping the FIFO.
- Deasserting tx_break returns to IDLE on the next tx_baud_pulse with UART_TX=1.
- tx_break has no effect on a frame already in progress.
When the macro is not defined, there is no tx_break port and no BREAK state.

Test Plan:
- Reset, no writes, 20 baud pulses -> UART_TX=1, fifo_empty=1, fifo_level=0, tx_busy=0 throughout.
- 8N1, push 0xA5 -> line carries 0,1,0,1,0,0,1,0,1,1 (one bit per pulse); tx_done pulses once; fifo_level 1 then 0.
- char_len=7, parity_en=1, even parity, stop2=1, push 0x41 -> 0, 1000001 LSB-first, parity 0, stop bits 1,1; then idle.
- Push 3 bytes 0x01,0x02,0x03 in consecutive cycles -> three frames with no idle bit between them; tx_done pulses 3 times; fifo_level sequence 3,2,1,0.
- FIFO_DEPTH=16, push 17 bytes while FSM is held in IDLE (no baud pulses) -> fifo_full=1 and fifo_level=16 after the 16th push; the 17th push pulses overflow; the first 16 bytes are sent in order.
- With UART_TX_BREAK_EN: set tx_break mid-frame of 0x55 -> frame completes, then UART_TX=0 held; clear tx_break -> UART_TX=1 after the next pulse and the queued byte is sent.
